// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD registered read ports, WB and LD write ports, ARM-style PC alias.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 4,
   parameter int unsigned NUM_RD    = 2,
   parameter int unsigned PC_IDX    = 15,
   parameter int unsigned PC_OFFSET = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NUM_RD-1:0]          rd_en,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_valid,
   input  logic                       wb_en,
   input  logic [ADDR_W-1:0]          wb_addr,
   input  logic [DATA_W-1:0]          wb_data,
   input  logic                       ld_en,
   input  logic [ADDR_W-1:0]          ld_addr,
   input  logic [DATA_W-1:0]          ld_data,
   input  logic [DATA_W-1:0]          pc_in
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
      $fatal(1, "regfile_mp: NUM_RD must be in 1..4");
   end

   logic [DATA_W-1:0] mem      [DEPTH];
   logic [DATA_W-1:0] rd_val_c [NUM_RD];
   logic [DATA_W-1:0] rd_q     [NUM_RD];
   logic [DATA_W-1:0] pc_rel_c;
   logic              wb_drop_c;

   assign pc_rel_c  = pc_in + DATA_W'(PC_OFFSET);
   assign wb_drop_c = ld_en && (ld_addr == wb_addr);

   // Storage: LD wins over WB when both target the same register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (wb_en && !wb_drop_c) begin
            mem[wb_addr] <= wb_data;
         end
         if (ld_en) begin
            mem[ld_addr] <= ld_data;
         end
      end
   end

   // Per-port read value; the PC alias overrides both storage and forwarding
   always_comb begin
      for (int k = 0; k < int'(NUM_RD); k++) begin
         logic [ADDR_W-1:0] a;
         a           = rd_addr[k*ADDR_W +: ADDR_W];
         rd_val_c[k] = mem[a];
`ifdef REGFILE_BYPASS_EN
         if (wb_en && (wb_addr == a)) begin
            rd_val_c[k] = wb_data;
         end
         if (ld_en && (ld_addr == a)) begin
            rd_val_c[k] = ld_data;
         end
`endif
         if (a == ADDR_W'(PC_IDX)) begin
            rd_val_c[k] = pc_rel_c;
         end
      end
   end

   // Registered read outputs; data holds when the port is idle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < int'(NUM_RD); k++) begin
            rd_q[k] <= '0;
         end
         rd_valid <= '0;
      end else begin
         for (int k = 0; k < int'(NUM_RD); k++) begin
            if (rd_en[k]) begin
               rd_q[k] <= rd_val_c[k];
            end
         end
         rd_valid <= rd_en;
      end
   end

   for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd_out
      assign rd_data[k*DATA_W +: DATA_W] = rd_q[k];
   end

endmodule
